size_explore_mac: RTL and testbench

SIZE_EXPLORE_MAC -- requirements
Module: size_explore_mac

---
 rtl/size_explore_mac.sv | 121 ++++++++++++
 tb/tb_size_explore_mac.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/size_explore_mac.sv
// Serial-load unsigned shift-add multiplier; SIZE_EXPLORE_ACCUM_EN turns the result register into an accumulator.
// Latency: WIDTH busy cycles after start, then a one-cycle done pulse (start may be re-asserted in that cycle).
// Backpressure: none; start is ignored while busy and operand shifting is frozen while busy or starting.
module size_explore_mac #(
    parameter int WIDTH = 8,
`ifdef SIZE_EXPLORE_ACCUM_EN
    localparam int RW = 2 * WIDTH + 8,
`else
    localparam int RW = 2 * WIDTH,
`endif
    localparam int SW = (RW / 8 > 1) ? $clog2(RW / 8) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          shift_en,
    input  logic          sin_a,
    input  logic          sin_b,
    input  logic          start,
    input  logic          acc_clr,
    input  logic [SW-1:0] byte_sel,
    output logic          busy,
    output logic          done,
    output logic [7:0]    dout
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] pp;
    logic [2*WIDTH-1:0] pp_step;
    logic [CW-1:0]      cnt;
    logic [RW-1:0]      result;
    logic [RW-1:0]      result_cmp;
    logic               last_step;
    logic [31:0]        sel_idx;

    assign busy      = (state == RUN);
    assign last_step = (state == RUN) && (cnt == CW'(WIDTH - 1));
    // mcand is pre-shifted each cycle, so the step only needs the multiplier LSB
    assign pp_step   = pp + (mplier[0] ? mcand : '0);

`ifdef SIZE_EXPLORE_ACCUM_EN
    assign result_cmp = (acc_clr ? '0 : result) + RW'(pp_step);
`else
    logic unused_acc_clr;
    assign unused_acc_clr = acc_clr;
    assign result_cmp     = pp_step;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_step) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa    <= '0;
            opb    <= '0;
            mplier <= '0;
            mcand  <= '0;
            pp     <= '0;
            cnt    <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            if (shift_en && (state == IDLE) && !start) begin
                opa <= {opa[WIDTH-2:0], sin_a};
                opb <= {opb[WIDTH-2:0], sin_b};
            end
            if (state == IDLE) begin
                if (start) begin
                    mcand  <= {{WIDTH{1'b0}}, opa};
                    mplier <= opb;
                    pp     <= '0;
                    cnt    <= '0;
                end
            end else begin
                pp     <= pp_step;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
            end
            done <= last_step;
            if (last_step) begin
                result <= result_cmp;
            end
`ifdef SIZE_EXPLORE_ACCUM_EN
            else if ((state == IDLE) && acc_clr) begin
                result <= '0;
            end
`endif
        end
    end

    assign sel_idx = 32'(byte_sel);

    always_comb begin
        dout = 8'h00;
        if (sel_idx < 32'(RW / 8)) begin
            dout = result[8*sel_idx +: 8];
        end
    end
endmodule

// File: tb/tb_size_explore_mac.sv
// Randomized self-checking bench for size_explore_mac (WIDTH=8) against an arithmetic reference model.
module tb_size_explore_mac;
    localparam int W = 8;
`ifdef SIZE_EXPLORE_ACCUM_EN
    localparam int RW = 2 * W + 8;
`else
    localparam int RW = 2 * W;
`endif
    localparam int SW = (RW / 8 > 1) ? $clog2(RW / 8) : 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          shift_en, sin_a, sin_b, start, acc_clr;
    logic [SW-1:0] byte_sel;
    logic          busy, done;
    logic [7:0]    dout;

    int n_chk = 0;
    int n_err = 0;

    // reference state: operands as the bench believes they were loaded, and the expected result
    logic [W-1:0]  m_opa, m_opb;
    logic [RW-1:0] m_res;

    size_explore_mac dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (shift_en),
        .sin_a    (sin_a),
        .sin_b    (sin_b),
        .start    (start),
        .acc_clr  (acc_clr),
        .byte_sel (byte_sel),
        .busy     (busy),
        .done     (done),
        .dout     (dout)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic read_result(input string tag);
        logic [7:0] exp_b;
        for (int s = 0; s < (1 << SW); s++) begin
            byte_sel = SW'(s);
            #1;
            exp_b = (s < RW / 8) ? m_res[8*s +: 8] : 8'h00;
            check($sformatf("%s_byte%0d", tag, s), dout, exp_b);
        end
        @(negedge clk);
    endtask

    task automatic shift_in(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int i = W - 1; i >= 0; i--) begin
            shift_en = 1'b1;
            sin_a    = a[i];
            sin_b    = b[i];
            @(negedge clk);
        end
        shift_en = 1'b0;
        m_opa    = a;
        m_opb    = b;
    endtask

    // clr_mode: 0 none, 1 pulse mid-run (must be ignored), 2 pulse on the completion edge
    task automatic do_mul(input string tag, input int clr_mode, input bit junk, input bit shift_at_start);
        logic [2*W-1:0] prod;
        int nb;
        prod  = (2*W)'(m_opa) * (2*W)'(m_opb);
        start = 1'b1;
        if (shift_at_start) begin
            shift_en = 1'b1;
            sin_a    = 1'($urandom);
            sin_b    = 1'($urandom);
        end
        @(negedge clk);
        start    = 1'b0;
        shift_en = 1'b0;
        nb       = 0;
        while (busy === 1'b1 && nb < 40) begin
            nb++;
            shift_en = junk ? 1'($urandom) : 1'b0;
            sin_a    = 1'($urandom);
            sin_b    = 1'($urandom);
            acc_clr  = (clr_mode == 1 && nb == 3) || (clr_mode == 2 && nb == W);
            @(negedge clk);
        end
        shift_en = 1'b0;
        acc_clr  = 1'b0;
        check({tag, "_busy_len"}, 64'(nb), 64'(W));
        check({tag, "_done_hi"}, 64'(done), 64'd1);
`ifdef SIZE_EXPLORE_ACCUM_EN
        if (clr_mode == 2) m_res = RW'(prod);
        else               m_res = m_res + RW'(prod);
`else
        m_res = prod;
`endif
        @(negedge clk);
        check({tag, "_done_lo"}, 64'(done), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
        read_result(tag);
    endtask

    task automatic idle_clear();
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
`ifdef SIZE_EXPLORE_ACCUM_EN
        m_res = '0;
`endif
        read_result("idle_clr");
    endtask

    task automatic back_to_back(input logic [W-1:0] a, input logic [W-1:0] b);
        int k, ndone, first_k, last_k, idle_cnt;
        logic [2*W-1:0] prod;
        shift_in(a, b);
        prod     = (2*W)'(a) * (2*W)'(b);
        start    = 1'b1;
        k        = 0;
        ndone    = 0;
        first_k  = -1;
        last_k   = -1;
        idle_cnt = 0;
        while (ndone < 3 && k < 60) begin
            @(negedge clk);
            k++;
            if (done === 1'b1) begin
                ndone++;
                if (first_k < 0) first_k = k;
                last_k = k;
`ifdef SIZE_EXPLORE_ACCUM_EN
                m_res = m_res + RW'(prod);
`else
                m_res = prod;
`endif
                if (ndone == 3) start = 1'b0;
            end else if (busy !== 1'b1) begin
                idle_cnt++;
            end
        end
        start = 1'b0;
        check("b2b_ndone", 64'(ndone), 64'd3);
        check("b2b_first", 64'(first_k), 64'(W + 1));
        check("b2b_period", 64'(last_k - first_k), 64'(2 * (W + 1)));
        check("b2b_no_gap", 64'(idle_cnt), 64'd0);
        @(negedge clk);
        check("b2b_stop", 64'(busy), 64'd0);
        read_result("b2b");
    endtask

    initial begin
        rst_n    = 1'b0;
        shift_en = 1'b0;
        sin_a    = 1'b0;
        sin_b    = 1'b0;
        start    = 1'b0;
        acc_clr  = 1'b0;
        byte_sel = '0;
        m_opa    = '0;
        m_opb    = '0;
        m_res    = '0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        @(negedge clk);
        read_result("rst");

        // start in the very first edge after release, operands cleared by reset
        rst_n = 1'b1;
        do_mul("first_after_rst", 0, 1'b0, 1'b0);

        shift_in(8'd13, 8'd11);
        do_mul("m13x11", 0, 1'b0, 1'b0);
        shift_in(8'd255, 8'd255);
        do_mul("m255x255", 0, 1'b0, 1'b0);
        idle_clear();
        shift_in(8'd3, 8'd5);
        do_mul("m3x5_clr", 2, 1'b0, 1'b0);

        // shifting while starting and while busy must not disturb the operands
        shift_in(8'd200, 8'd77);
        do_mul("shift_at_start", 1, 1'b1, 1'b1);
        do_mul("reuse_ops", 0, 1'b0, 1'b0);

        back_to_back(8'd3, 8'd5);

        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(3) != 0) shift_in(W'($urandom), W'($urandom));
            if ($urandom_range(5) == 0) idle_clear();
            do_mul($sformatf("rnd%0d", it), int'($urandom_range(2)), 1'($urandom), 1'($urandom));
        end

        // reset in the 4th run cycle aborts with no result update and no later done
        shift_in(8'd13, 8'd11);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_was_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        m_res = '0;
        m_opa = '0;
        m_opb = '0;
        @(negedge clk);
        read_result("abort");
        rst_n = 1'b1;
        begin
            int ndone_after = 0;
            for (int i = 0; i < 3 * W; i++) begin
                @(negedge clk);
                if (done !== 1'b0 || busy !== 1'b0) ndone_after++;
            end
            check("abort_no_done", 64'(ndone_after), 64'd0);
        end
        read_result("abort_hold");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
